freq_report_tx: RTL and testbench

//  Downstream reporting stage for the frequency counter. Captures the averaged
//  10-bit freq_khz result on request and converts it to 4 decimal digits.

---
 rtl/freq_counter_pkg.sv | 21 ++
 rtl/bin2bcd_seq.sv | 41 ++++
 rtl/freq_report_tx.sv | 109 ++++++++++
 tb/tb_freq_report_tx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/freq_counter_pkg.sv
// freq_counter_pkg: shared constants, FSM state type and frame length for the frequency reporter.
// FREQ_REPORT_UNITS_EN selects the 10-byte "dddd kHz\r\n" frame instead of "dddd\r\n".
package freq_counter_pkg;
    localparam int FREQ_W = 10;
    typedef enum logic [2:0] {IDLE, CONVERT, LOAD, START_B, DATA, STOP_B} tx_state_t;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_K = 8'h6B;
    localparam logic [7:0] ASCII_H = 8'h48;
    localparam logic [7:0] ASCII_Z = 8'h7A;
    function automatic int nbytes();
`ifdef FREQ_REPORT_UNITS_EN
        return 10;
`else
        return 6;
`endif
    endfunction
    localparam int NBYTES = nbytes();
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to 4-digit BCD, one input bit per clock.
// valid is high during the final step, so bcd holds the result from the following cycle.
module bin2bcd_seq
    import freq_counter_pkg::*;
(
    input  logic              Clock,
    input  logic              nReset,
    input  logic              go,
    input  logic [FREQ_W-1:0] bin,
    output logic [15:0]       bcd,
    output logic              valid
);
    localparam int CW = $clog2(FREQ_W + 1);
    logic [FREQ_W-1:0] sh;
    logic [CW-1:0] cnt;
    logic [15:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    assign valid = cnt == CW'(1);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sh  <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (go) begin
            sh  <= bin;
            bcd <= '0;
            cnt <= CW'(FREQ_W);
        end else if (cnt != '0) begin
            bcd <= {adj[14:0], sh[FREQ_W-1]};
            sh  <= sh << 1;
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/freq_report_tx.sv
// freq_report_tx: captures freq_khz on request and sends it as a fixed-width ASCII line over 8N1 UART.
// Define FREQ_REPORT_UNITS_EN to append " kHz" before CR LF.
module freq_report_tx
    import freq_counter_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [FREQ_W-1:0] freq_khz,
    input  logic              start,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [3:0] LAST = 4'(NBYTES - 1);

    tx_state_t state;
    logic [BW-1:0] baud;
    logic [2:0] bit_idx;
    logic [3:0] byte_idx, nxt;
    logic [7:0] sr, byte_sel, tail;
    logic [15:0] bcd;
    logic [3:0] digit;
    logic go, conv_last, baud_wrap, in_bit;

    assign go = start && !busy;

    bin2bcd_seq u_bcd (
        .Clock (Clock),
        .nReset(nReset),
        .go    (go),
        .bin   (freq_khz),
        .bcd   (bcd),
        .valid (conv_last)
    );

    // LOAD picks the first byte; the last stop cycle picks the following one
    assign nxt = state == LOAD ? byte_idx : byte_idx + 4'd1;
    assign digit = nxt == 4'd0 ? bcd[15:12] : nxt == 4'd1 ? bcd[11:8] : nxt == 4'd2 ? bcd[7:4] : bcd[3:0];
`ifdef FREQ_REPORT_UNITS_EN
    assign tail = nxt == 4'd4 ? ASCII_SP : nxt == 4'd5 ? ASCII_K : nxt == 4'd6 ? ASCII_H :
                  nxt == 4'd7 ? ASCII_Z : nxt == 4'd8 ? ASCII_CR : ASCII_LF;
`else
    assign tail = nxt == 4'd4 ? ASCII_CR : ASCII_LF;
`endif
    assign byte_sel = nxt < 4'd4 ? (ASCII_0 | {4'h0, digit}) : tail;

    assign baud_wrap = baud == BW'(BAUD_DIV - 1);
    assign in_bit = state == START_B || state == DATA || state == STOP_B;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            sr       <= '0;
        end else begin
            done <= 1'b0;
            baud <= in_bit && !baud_wrap ? baud + BW'(1) : '0;
            case (state)
                IDLE: if (go) begin
                    state    <= CONVERT;
                    busy     <= 1'b1;
                    byte_idx <= '0;
                end
                CONVERT: if (conv_last) state <= LOAD;
                LOAD: begin
                    sr    <= byte_sel;
                    tx    <= 1'b0;
                    state <= START_B;
                end
                START_B: if (baud_wrap) begin
                    tx      <= sr[0];
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (baud_wrap) begin
                    if (bit_idx == 3'd7) begin
                        tx    <= 1'b1;
                        state <= STOP_B;
                    end else begin
                        tx      <= sr[1];
                        sr      <= sr >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP_B: if (baud_wrap) begin
                    if (byte_idx == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 4'd1;
                        sr       <= byte_sel;
                        tx       <= 1'b0;
                        state    <= START_B;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_freq_report_tx.sv
// tb_freq_report_tx: directed frames through a mid-bit UART receiver with cycle-exact timing checks.
module tb_freq_report_tx;
    localparam int BD = 4;
`ifdef FREQ_REPORT_UNITS_EN
    localparam int NB = 10;
`else
    localparam int NB = 6;
`endif

    logic Clock = 1'b0, nReset = 1'b0, start = 1'b0;
    logic [9:0] freq_khz = '0;
    logic tx, busy, done;
    int checks = 0, errors = 0, cyc = 0, busy_cnt = 0;

    typedef struct {
        logic [9:0]  f;
        logic [31:0] dig;
    } vec_t;
    vec_t v[5];

    freq_report_tx #(.BAUD_DIV(BD)) dut (
        .Clock   (Clock),
        .nReset  (nReset),
        .freq_khz(freq_khz),
        .start   (start),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;
    always @(negedge Clock) if (busy) busy_cnt <= busy_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] dig, input int k);
        if (k < 4) return dig[31-8*k -: 8];
        return k == NB-2 ? 8'h0D : k == NB-1 ? 8'h0A : k == 4 ? 8'h20 : k == 5 ? 8'h6B : k == 6 ? 8'h48 : 8'h7A;
    endfunction

    task automatic recv_byte(input string tag, output logic [7:0] b, output int fall);
        int n = 0;
        b = '0;
        fall = -1;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge Clock);
            n++;
        end
        if (tx !== 1'b0) begin
            check({tag, " start bit timeout"}, int'(tx), 0);
            return;
        end
        fall = cyc;
        repeat (BD/2) @(negedge Clock);
        check({tag, " start bit"}, int'(tx), 0);
        for (int i = 0; i < 8; i++) begin
            repeat (BD) @(negedge Clock);
            b[i] = tx;
        end
        repeat (BD) @(negedge Clock);
        check({tag, " stop bit"}, int'(tx), 1);
    endtask

    task automatic recv_frame(input string tag, input logic [31:0] dig, input int acc);
        logic [7:0] b;
        int f, prev = 0, n = 0;
        for (int k = 0; k < NB; k++) begin
            recv_byte($sformatf("%s b%0d", tag, k), b, f);
            if (k == 0) check({tag, " first tx fall"}, f, acc + 11);
            else check($sformatf("%s b%0d back-to-back", tag, k), f, prev + 10*BD);
            check($sformatf("%s b%0d value", tag, k), int'(b), int'(exp_byte(dig, k)));
            prev = f;
        end
        while (!done && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check({tag, " done edge"}, cyc, acc + 11 + NB*10*BD);
        check({tag, " busy at done"}, int'(busy), 0);
    endtask

    task automatic pulse(input logic [9:0] f, output int acc);
        @(negedge Clock);
        freq_khz = f;
        start = 1'b1;
        busy_cnt = 0;
        @(negedge Clock);
        acc = cyc;
        start = 1'b0;
    endtask

    initial begin
        int acc, d;
        v[0] = '{10'd0, "0000"};
        v[1] = '{10'd1023, "1023"};
        v[2] = '{10'd507, "0507"};
        v[3] = '{10'd512, "0512"};
        v[4] = '{10'd7, "0007"};

        repeat (3) @(negedge Clock);
        check("reset tx", int'(tx), 1);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        nReset = 1'b1;
        repeat (2) @(negedge Clock);

        for (int i = 0; i < 5; i++) begin
            pulse(v[i].f, acc);
            check($sformatf("vec%0d busy after accept", i), int'(busy), 1);
            recv_frame($sformatf("vec%0d", i), v[i].dig, acc);
            if (i == 0) check("busy length", busy_cnt, 11 + NB*10*BD);
            repeat (3) @(negedge Clock);
        end

        pulse(10'd42, acc);
        fork
            recv_frame("ignore", "0042", acc);
            begin
                repeat (40) @(negedge Clock);
                freq_khz = 10'd999;
                start = 1'b1;
                @(negedge Clock);
                start = 1'b0;
                repeat (100) @(negedge Clock);
                start = 1'b1;
                @(negedge Clock);
                start = 1'b0;
            end
        join
        busy_cnt = 0;
        repeat (60) @(negedge Clock);
        check("no queued frame busy", busy_cnt, 0);
        check("no queued frame tx", int'(tx), 1);

        pulse(10'd555, acc);
        repeat (11 + 2*10*BD + 3*BD) @(negedge Clock);
        check("pre-reset busy", int'(busy), 1);
        #2 nReset = 1'b0;
        #1;
        check("async reset tx", int'(tx), 1);
        check("async reset busy", int'(busy), 0);
        check("async reset done", int'(done), 0);
        @(negedge Clock);
        nReset = 1'b1;
        repeat (2) @(negedge Clock);
        pulse(10'd100, acc);
        recv_frame("post-reset", "0100", acc);

        @(negedge Clock);
        freq_khz = 10'd7;
        start = 1'b1;
        @(negedge Clock);
        acc = cyc;
        recv_frame("held1", "0007", acc);
        d = cyc;
        recv_frame("held2", "0007", d + 1);
        start = 1'b0;
        busy_cnt = 0;
        repeat (20) @(negedge Clock);
        check("held release busy", busy_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
